// File: rtl/wb_port_arb.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writers.
// Optional x0 write suppression is enabled by defining WB_ARB_X0_FILTER_EN.
module wb_port_arb #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    localparam int SW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    wb_rd_wen_o,
    output logic [4:0]              wb_rd_o,
    output logic [XLEN-1:0]         wb_rd_wdata_o,
    output logic [SW-1:0]           wb_src_o,
    output logic                    fwd_valid_o,
    output logic [4:0]              fwd_rd_o,
    output logic [XLEN-1:0]         fwd_data_o
);

    // Handshake: writer r transfers when req_valid_i[r] & req_ready_o[r] in the same
    // cycle; ready is a function of valid, so valid must never wait on ready.

    logic [SW-1:0]   ptr_q, ptr_d;
    logic            wen_q, wen_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [SW-1:0]   src_q, src_d;

    logic            grant_hit;
    logic [SW-1:0]   grant_idx;

    // Position "off" steps after base in the circular search order.
    function automatic logic [SW-1:0] rot_idx(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return SW'(s);
    endfunction

    always_comb begin
        grant_hit   = 1'b0;
        grant_idx   = '0;
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_hit && req_valid_i[rot_idx(ptr_q, k)]) begin
                grant_hit = 1'b1;
                grant_idx = rot_idx(ptr_q, k);
            end
        end
        if (rst_i) grant_hit = 1'b0;
        if (grant_hit) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        src_d  = src_q;
        if (grant_hit) begin
            rd_d   = req_rd_i[5*grant_idx +: 5];
            data_d = req_wdata_i[XLEN*grant_idx +: XLEN];
            src_d  = grant_idx;
`ifdef WB_ARB_X0_FILTER_EN
            wen_d  = (req_rd_i[5*grant_idx +: 5] != 5'd0);
`else
            wen_d  = 1'b1;
`endif
            ptr_d  = (grant_idx == SW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            src_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            src_q  <= src_d;
        end
    end

    // The same registered write feeds the regfile and the forwarding bus.
    assign wb_rd_wen_o   = wen_q;
    assign wb_rd_o       = rd_q;
    assign wb_rd_wdata_o = data_q;
    assign wb_src_o      = src_q;
    assign fwd_valid_o   = wen_q;
    assign fwd_rd_o      = rd_q;
    assign fwd_data_o    = data_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed scenarios plus randomized writers
// compared against a round-robin reference model and an expected-write queue.
module tb_wb_port_arb;
    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int SW   = $clog2(N);
    localparam int W    = 1 + SW + 5 + XLEN;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N*5-1:0]    rd_bus;
    logic [N*XLEN-1:0] data_bus;
    logic [N-1:0]      req_ready;
    logic              wb_wen, fwd_valid;
    logic [4:0]        wb_rd, fwd_rd;
    logic [XLEN-1:0]   wb_data, fwd_data;
    logic [SW-1:0]     wb_src;

    wb_port_arb #(.NUM_REQ(N), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_rd_i(rd_bus), .req_wdata_i(data_bus),
        .req_ready_o(req_ready),
        .wb_rd_wen_o(wb_wen), .wb_rd_o(wb_rd), .wb_rd_wdata_o(wb_data), .wb_src_o(wb_src),
        .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int m_ptr = 0;
    int last_g;
    logic            exp_wen;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    int              exp_src;
    logic [XLEN-1:0] rf [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // First valid writer met when walking ptr, ptr+1, ... around the ring.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_w(input int r, input logic v, input logic [4:0] d, input logic [XLEN-1:0] x);
        valid[r] = v;
        rd_bus[5*r +: 5] = d;
        data_bus[XLEN*r +: XLEN] = x;
    endtask

    // One clock: check the combinational grant, predict, then check the registered write.
    task automatic step(input logic r_in);
        logic [N-1:0] exp_ready;
        logic [W-1:0] e;
        int g;
        rst = r_in;
        #1;
        g = r_in ? -1 : model_grant(valid);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("ready", 64'(req_ready), 64'(exp_ready));
        if (r_in) begin
            m_ptr = 0; exp_wen = 1'b0; exp_rd = '0; exp_data = '0; exp_src = 0;
        end else if (g >= 0) begin
            exp_rd   = rd_bus[5*g +: 5];
            exp_data = data_bus[XLEN*g +: XLEN];
            exp_src  = g;
`ifdef WB_ARB_X0_FILTER_EN
            exp_wen  = (exp_rd != 5'd0);
`else
            exp_wen  = 1'b1;
`endif
            m_ptr    = (g + 1) % N;
        end else begin
            exp_wen = 1'b0;
        end
        exp_q.push_back({exp_wen, SW'(exp_src), exp_rd, exp_data});
        last_g = g;
        @(posedge clk);
        #1;
        if (wb_wen) rf[wb_rd] = wb_data;
        e = exp_q.pop_front();
        check("wen",       64'(wb_wen),    64'(e[W-1]));
        check("src",       64'(wb_src),    64'(e[XLEN+5 +: SW]));
        check("rd",        64'(wb_rd),     64'(e[XLEN +: 5]));
        check("data",      64'(wb_data),   64'(e[XLEN-1:0]));
        check("fwd_valid", 64'(fwd_valid), 64'(e[W-1]));
        check("fwd_rd",    64'(fwd_rd),    64'(e[XLEN +: 5]));
        check("fwd_data",  64'(fwd_data),  64'(e[XLEN-1:0]));
    endtask

    // random writer state
    logic            pend [N];
    logic [4:0]      p_rd [N];
    logic [XLEN-1:0] p_dat[N];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        valid = '0; rd_bus = '0; data_bus = '0; rst = 1'b1;

        // reset with all writers requesting, then release grants writer 0
        set_w(0, 1'b1, 5'd3, 32'h1111_0000);
        set_w(1, 1'b1, 5'd4, 32'h2222_0000);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("post_reset_grant", 64'(last_g), 64'd0);

        // single writer
        valid = '0;
        set_w(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step(1'b0);
        valid = '0;
        set_w(1, 1'b1, 5'd9, 32'h0000_0009);
        step(1'b0);

        // both valid for four cycles from ptr 0: 0,1,0,1
        for (int c = 0; c < 4; c++) begin
            set_w(0, 1'b1, 5'd10, 32'hA000_0000 + c);
            set_w(1, 1'b1, 5'd11, 32'hB000_0000 + c);
            step(1'b0);
            check("rr_order", 64'(last_g), 64'(c % 2));
        end

        // grant to 1, idle gap, then req1 again granted at once
        valid = '0;
        set_w(1, 1'b1, 5'd12, 32'h0000_0C0C);
        step(1'b0);
        valid = '0;
        for (int c = 0; c < 3; c++) step(1'b0);
        set_w(1, 1'b1, 5'd13, 32'h0000_0D0D);
        step(1'b0);
        check("idle_regrant", 64'(last_g), 64'd1);

        // same rd from both writers in consecutive grants
        valid = '0;
        set_w(0, 1'b1, 5'd7, 32'd1);
        set_w(1, 1'b1, 5'd7, 32'd2);
        step(1'b0);
        set_w(last_g, 1'b0, 5'd7, 32'd0);
        step(1'b0);
        valid = '0;
        step(1'b0);
        check("x7_final", 64'(rf[7]), 64'd2);

        // x0 write
        set_w(0, 1'b1, 5'd0, 32'd55);
        step(1'b0);
        valid = '0;
        step(1'b0);

        // randomized writers that hold their request until handshake
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r]  = 1'b1;
                    p_rd[r]  = 5'($urandom_range(0, 31));
                    p_dat[r] = $urandom;
                end
                set_w(r, pend[r], p_rd[r], p_dat[r]);
            end
            step($urandom_range(0, 49) == 0);
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        valid = '0;
        step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
